// File: rtl/ifq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ifq_pkg
// Description : Shared constants and the queue-entry type for the
//               instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package ifq_pkg;

  // Address / instruction width shared by the fetch path.
  localparam int c_XLEN = 32;

  // Default number of queue entries.
  localparam int c_DEPTH = 4;

  // Instruction presented to decode when the queue has nothing valid
  // (addi x0, x0, 0).
  localparam logic [c_XLEN-1:0] c_NOP = 32'h0000_0013;

  // One queue slot: fetch address, returned instruction word and a flag
  // saying the instruction word has arrived from memory.
  typedef struct packed {
    logic [c_XLEN-1:0] pc;
    logic [c_XLEN-1:0] instr;
    logic              filled;
  } ifq_entry_t;

endpackage : ifq_pkg
`default_nettype wire

// File: rtl/ifetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction fetch queue. Issues in-order fetch requests from
//               the PC register, collects in-order memory responses into a
//               small circular buffer and presents the oldest instruction to
//               decode. A flush drops everything queued and arranges for the
//               responses of still-outstanding requests to be discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH = c_DEPTH,
  parameter int XLEN  = c_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_enable,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            flush,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);

  // Pointer width and counter width (counters must be able to hold DEPTH).
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // DEPTH widened so that count + drop can be compared without overflow.
  localparam logic [CW:0] c_DEPTH_EXT = (CW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ifq_entry_t       entry_q [DEPTH];

  logic [PW-1:0]    head_q;   // oldest entry, presented to decode
  logic [PW-1:0]    fill_q;   // oldest entry still waiting for its response
  logic [PW-1:0]    tail_q;   // next free slot for a new request
  logic [CW-1:0]    count_q;  // occupied entries
  logic [CW-1:0]    pend_q;   // occupied entries not yet filled
  logic [CW-1:0]    drop_q;   // responses still to be discarded after a flush

  logic [PW-1:0]    head_d;
  logic [PW-1:0]    fill_d;
  logic [PW-1:0]    tail_d;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    pend_d;
  logic [CW-1:0]    drop_d;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic             w_room;
  logic             w_push;
  logic             w_pop;
  logic             w_fill;
  logic             w_discard;
  logic [CW:0]      w_drop_sum;
  ifq_entry_t       w_head;

  // Issue only when the registered occupancy plus the responses still owed to
  // flushed requests leaves a free slot; a same-cycle pop does not count.
  // Reset gates the request combinationally because it is asynchronous.
  always_comb begin
    w_room        = ({1'b0, count_q} + {1'b0, drop_q}) < c_DEPTH_EXT;
    mem_req_valid = !reset && !flush && w_room;
    mem_req_addr  = pc;
    w_push        = mem_req_valid && mem_req_ready;
    pc_enable     = w_push;
  end

  // Head presentation to decode, and the response routing decision.
  always_comb begin
    w_head    = entry_q[head_q];
    if_valid  = w_head.filled && (count_q != '0);
    if_instr  = if_valid ? w_head.instr : c_NOP;
    if_pc     = if_valid ? w_head.pc    : '0;
    w_pop     = if_valid && id_ready && !flush;
    w_discard = mem_rsp_valid && (drop_q != '0);
    // A response with nothing pending and nothing to drop is simply ignored.
    w_fill    = mem_rsp_valid && (drop_q == '0) && (pend_q != '0) && !flush;
  end

  // Next-state for pointers and counters; a flush empties the queue and turns
  // every unfilled entry into a response that must be thrown away.
  always_comb begin
    head_d     = head_q;
    fill_d     = fill_q;
    tail_d     = tail_q;
    count_d    = count_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    w_drop_sum = {1'b0, drop_q} + {1'b0, pend_q};

    if (flush) begin
      head_d  = '0;
      fill_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pend_d  = '0;
      // A response arriving in the flush cycle settles one of the owed ones.
      if (mem_rsp_valid && (w_drop_sum != '0)) begin
        w_drop_sum = w_drop_sum - 1'b1;
      end
      drop_d = w_drop_sum[CW-1:0];
    end else begin
      tail_d  = tail_q + PW'(w_push);
      fill_d  = fill_q + PW'(w_fill);
      head_d  = head_q + PW'(w_pop);
      count_d = count_q + CW'(w_push) - CW'(w_pop);
      pend_d  = pend_q + CW'(w_push) - CW'(w_fill);
      drop_d  = drop_q - CW'(w_discard);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // Pointer and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      fill_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // Entry storage: new requests land at the tail unfilled, responses fill the
  // oldest unfilled entry. Push and fill never target the same slot because a
  // push is impossible while every slot is occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i].filled <= 1'b0;
      end
    end else begin
      if (w_push) begin
        entry_q[tail_q].pc     <= pc;
        entry_q[tail_q].instr  <= c_NOP;
        entry_q[tail_q].filled <= 1'b0;
      end
      if (w_fill) begin
        entry_q[fill_q].instr  <= mem_rsp_data;
        entry_q[fill_q].filled <= 1'b1;
      end
    end
  end

endmodule : ifetch_queue
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Self-checking bench for ifetch_queue. A queue-based model of
//               the fetch queue and a simple in-order memory run alongside
//               the DUT; directed scenarios pin the model with literal values,
//               then a long randomized run is checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam int          XLEN  = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // DUT connections
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_enable;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        flush = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model of the queue: fetch addresses and instruction words in age order,
  // how many of the oldest entries already hold their instruction, and how
  // many future responses belong to flushed requests.
  logic [31:0] m_pc  [$];
  logic [31:0] m_ins [$];
  int          m_nfill = 0;
  int          m_drop  = 0;

  // Memory model: addresses accepted and not yet answered, in order.
  logic [31:0] memq [$];
  logic [31:0] pc_nxt = 32'h100;

  // Stimulus knobs
  bit          g_reset = 1'b1;
  bit          g_ready = 1'b0;
  bit          g_idr   = 1'b0;
  bit          g_flush = 1'b0;
  bit          g_force = 1'b0;
  int          g_pct   = 0;
  logic [31:0] g_target = '0;

  ifetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pc_enable     (pc_enable),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .flush         (flush),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready)
  );

  always #5 clk = ~clk;

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a << 4) ^ 32'h0BAD_0013;
  endfunction

  function automatic bit m_req_ok();
    return !reset && !flush && ((m_pc.size() + m_drop) < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  logic [31:0] e_ins, e_pc;
  bit          e_req, e_iv;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_pc_enable", {31'b0, pc_enable},     32'd0);
      chk("rst_if_valid",  {31'b0, if_valid},      32'd0);
      chk("rst_if_instr",  if_instr,               NOP);
      chk("rst_if_pc",     if_pc,                  32'd0);
    end else begin
      e_req = m_req_ok();
      e_iv  = (m_nfill > 0);
      e_ins = NOP;
      e_pc  = '0;
      if (e_iv) begin
        e_ins = m_ins[0];
        e_pc  = m_pc[0];
      end
      chk("req_valid", {31'b0, mem_req_valid}, {31'b0, e_req});
      chk("pc_enable", {31'b0, pc_enable},     {31'b0, e_req && mem_req_ready});
      chk("req_addr",  mem_req_addr,           pc);
      chk("if_valid",  {31'b0, if_valid},      {31'b0, e_iv});
      chk("if_instr",  if_instr,               e_ins);
      chk("if_pc",     if_pc,                  e_pc);
    end
  end

  // Model and memory state update on the active edge.
  bit acc, pop;
  int unf, d;
  always @(posedge clk) begin
    if (reset) begin
      m_pc.delete();
      m_ins.delete();
      m_nfill = 0;
      m_drop  = 0;
      memq.delete();
    end else begin
      acc = m_req_ok() && mem_req_ready;
      if (mem_rsp_valid && memq.size() > 0) void'(memq.pop_front());
      if (acc) begin
        memq.push_back(pc);
        pc_nxt = pc + 32'd4;
      end
      if (flush) begin
        unf = m_pc.size() - m_nfill;
        d   = m_drop + unf - (mem_rsp_valid ? 1 : 0);
        m_drop = (d < 0) ? 0 : d;
        m_pc.delete();
        m_ins.delete();
        m_nfill = 0;
      end else begin
        pop = (m_nfill > 0) && id_ready;
        if (mem_rsp_valid) begin
          if (m_drop > 0) begin
            m_drop--;
          end else if (m_pc.size() > m_nfill) begin
            m_ins[m_nfill] = mem_rsp_data;
            m_nfill++;
          end
        end
        if (pop) begin
          void'(m_pc.pop_front());
          void'(m_ins.pop_front());
          m_nfill--;
        end
        if (acc) begin
          m_pc.push_back(pc);
          m_ins.push_back(NOP);
        end
      end
    end
  end

  // One clock of stimulus, driven on the falling edge; returns shortly after
  // so the caller can inspect outputs for that cycle.
  task automatic cyc();
    @(negedge clk);
    reset         = g_reset;
    mem_req_ready = g_ready;
    id_ready      = g_idr;
    flush         = g_flush;
    if (g_flush) pc_nxt = g_target;
    pc = pc_nxt;
    if (g_force && memq.size() == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
    end else if (memq.size() > 0 && int'($urandom_range(99)) < g_pct) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mdata(memq[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    #2;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    g_reset = 1'b1; g_flush = 1'b0; g_force = 1'b0;
    cyc();
    cyc();
    g_reset = 1'b0;
    pc_nxt  = start_pc;
  endtask

  int n;

  initial begin
    // Reset state, with ready held high to show requests stay gated.
    g_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("L_rst_req", {31'b0, mem_req_valid}, 32'd0);
    chk("L_rst_pce", {31'b0, pc_enable},     32'd0);
    chk("L_rst_iv",  {31'b0, if_valid},      32'd0);
    chk("L_rst_ins", if_instr,               NOP);
    chk("L_rst_pc",  if_pc,                  32'd0);

    // Streaming with a one-cycle memory.
    g_reset = 1'b0; pc_nxt = 32'h100; g_ready = 1'b1; g_idr = 1'b1; g_pct = 100;
    cyc();
    chk("L_s_req",  {31'b0, mem_req_valid}, 32'd1);
    chk("L_s_addr", mem_req_addr,           32'h100);
    chk("L_s_pce",  {31'b0, pc_enable},     32'd1);
    cyc();
    chk("L_s_addr2",  mem_req_addr,       32'h104);
    chk("L_s_nobyp",  {31'b0, if_valid},  32'd0);
    cyc();
    chk("L_s_iv",  {31'b0, if_valid}, 32'd1);
    chk("L_s_pc",  if_pc,             32'h100);
    chk("L_s_ins", if_instr,          mdata(32'h100));

    // Decode stalled: exactly DEPTH requests, then pop + fill on a full queue.
    do_reset(32'h100);
    g_idr = 1'b0; g_pct = 0; g_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (pc_enable === 1'b1) n++;
    end
    chk("L_full_cnt", n, 32'd4);
    chk("L_full_req", {31'b0, mem_req_valid}, 32'd0);
    g_pct = 100;
    cyc();
    g_idr = 1'b1;
    cyc();
    chk("L_pop_req", {31'b0, mem_req_valid}, 32'd0);
    chk("L_pop_pce", {31'b0, pc_enable},     32'd0);
    chk("L_pop_pc",  if_pc,                  32'h100);
    g_idr = 1'b0; g_pct = 0;
    cyc();
    chk("L_after_req",  {31'b0, mem_req_valid}, 32'd1);
    chk("L_after_addr", mem_req_addr,           32'h110);
    chk("L_after_pc",   if_pc,                  32'h104);

    // Flush with three requests in flight and no response that cycle.
    do_reset(32'h100);
    g_pct = 0; g_idr = 1'b0; g_ready = 1'b1;
    cyc(); cyc(); cyc();
    g_flush = 1'b1; g_target = 32'h200;
    cyc();
    chk("L_fl_req", {31'b0, mem_req_valid}, 32'd0);
    g_flush = 1'b0;
    cyc();
    chk("L_fl_req2", {31'b0, mem_req_valid}, 32'd1);
    chk("L_fl_addr", mem_req_addr,           32'h200);
    g_ready = 1'b0;
    cyc();
    chk("L_fl_owed", {31'b0, mem_req_valid}, 32'd0);
    g_pct = 100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("L_fl_drop_iv", {31'b0, if_valid}, 32'd0);
    end
    cyc();
    chk("L_fl_iv",  {31'b0, if_valid}, 32'd1);
    chk("L_fl_pc",  if_pc,             32'h200);
    chk("L_fl_ins", if_instr,          mdata(32'h200));

    // Flush coinciding with a response, two entries unfilled.
    do_reset(32'h300);
    g_pct = 0; g_ready = 1'b1; g_idr = 1'b0;
    cyc(); cyc();
    g_flush = 1'b1; g_target = 32'h400; g_pct = 100;
    cyc();
    g_flush = 1'b0; g_pct = 0;
    cyc();
    chk("L_fr_iv",   {31'b0, if_valid},      32'd0);
    chk("L_fr_req",  {31'b0, mem_req_valid}, 32'd1);
    chk("L_fr_addr", mem_req_addr,           32'h400);
    g_ready = 1'b0; g_pct = 100;
    cyc();
    chk("L_fr_iv1", {31'b0, if_valid}, 32'd0);
    cyc();
    chk("L_fr_iv2", {31'b0, if_valid}, 32'd0);
    cyc();
    chk("L_fr_iv3", {31'b0, if_valid}, 32'd1);
    chk("L_fr_pc",  if_pc,             32'h400);

    // Response with nothing outstanding.
    do_reset(32'h500);
    g_ready = 1'b0; g_force = 1'b1; g_pct = 0;
    cyc();
    g_force = 1'b0;
    cyc();
    chk("L_sp_iv",  {31'b0, if_valid}, 32'd0);
    chk("L_sp_ins", if_instr,          NOP);
    g_ready = 1'b1;
    cyc();
    chk("L_sp_req", {31'b0, mem_req_valid}, 32'd1);

    // Randomized run checked every cycle by the model.
    do_reset(32'h1000);
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) g_pct = int'($urandom_range(10, 100));
      g_ready  = ($urandom_range(99) < 75);
      g_idr    = ($urandom_range(99) < 60);
      g_flush  = ($urandom_range(99) < 4);
      g_target = $urandom & 32'h0000_FFFC;
      g_force  = ($urandom_range(99) < 3);
      g_reset  = ($urandom_range(999) < 5);
      cyc();
    end
    g_reset = 1'b0; g_flush = 1'b0; g_force = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifetch_queue
`default_nettype wire
